// File: rtl/gate_chk_pkg.sv
// ============================================================================
// gate_chk_pkg
// Shared types, truth-table width helper and 2-input gate truth tables.
// Rev 1.0
// ============================================================================
`default_nettype none

package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    function automatic int tt_width(input int n_in);
        return 1 << n_in;
    endfunction

    // Bit i is the gate output for input combination i.
    localparam logic [3:0] TT_XNOR2 = 4'b1001;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_XOR2  = 4'b0110;

endpackage

`default_nettype wire

// File: rtl/chk_coverage_tracker.sv
// ============================================================================
// chk_coverage_tracker
// Bitmap of input combinations seen; flags when the current accept completes it.
// Rev 1.0
// ============================================================================
`default_nettype none

module chk_coverage_tracker
    import gate_chk_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear_i,
    input  logic            set_i,
    input  logic [N_IN-1:0] vec_i,
    output logic            all_cov_next_o
);

    localparam int TT_W = tt_width(N_IN);

    logic [TT_W-1:0] cover_q;
    logic [TT_W-1:0] cover_d;
    logic [TT_W-1:0] onehot_w;

    assign onehot_w = {{(TT_W-1){1'b0}}, 1'b1} << vec_i;

    // Only meaningful together with set_i; the top qualifies it with accept.
    assign all_cov_next_o = &(cover_q | onehot_w);

    always_comb begin
        cover_d = cover_q;
        if (clear_i) begin
            cover_d = '0;
        end else if (set_i) begin
            cover_d = cover_q | onehot_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cover_q <= '0;
        end else begin
            cover_q <= cover_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/gate_response_checker.sv
// ============================================================================
// gate_response_checker
// Checks (in_vec, in_y) samples against a latched truth table until every
// combination is covered. Optional idle watchdog: CHK_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter int N_IN        = 2,
    parameter int ERR_W       = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [tt_width(N_IN)-1:0] truth_table,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_IN-1:0]           in_vec,
    input  logic                      in_y,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [ERR_W-1:0]          err_count,
    output logic                      first_err_valid,
    output logic [N_IN-1:0]           first_err_vec,
    output logic                      timeout
);

    localparam int              TT_W    = tt_width(N_IN);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    chk_state_e      state_q, state_d;
    logic [TT_W-1:0] tt_q, tt_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic            fe_valid_q, fe_valid_d;
    logic [N_IN-1:0] fe_vec_q, fe_vec_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            to_q, to_d;

    logic            start_go_w;
    logic            accept_w;
    logic            mismatch_w;
    logic [ERR_W-1:0] err_inc_w;
    logic            all_cov_next_w;
    logic            timeout_fire_w;

    assign start_go_w = start && (state_q != RUN);
    assign accept_w   = in_valid && (state_q == RUN);
    assign mismatch_w = accept_w && (in_y != tt_q[in_vec]);
    assign err_inc_w  = (mismatch_w && (err_q != ERR_MAX)) ? err_q + ERR_W'(1) : err_q;

    chk_coverage_tracker #(
        .N_IN (N_IN)
    ) u_cov (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_i        (start_go_w),
        .set_i          (accept_w),
        .vec_i          (in_vec),
        .all_cov_next_o (all_cov_next_w)
    );

`ifdef CHK_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;

    always_comb begin
        idle_d = idle_q;
        if (start_go_w || accept_w) begin
            idle_d = '0;
        end else if (state_q == RUN) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    // Fires on the TIMEOUT_CYC-th consecutive non-accepting edge in RUN.
    assign timeout_fire_w = (state_q == RUN) && !accept_w &&
                            (idle_q == IDLE_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_fire_w     = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        tt_d       = tt_q;
        err_d      = err_q;
        fe_valid_d = fe_valid_q;
        fe_vec_d   = fe_vec_q;
        done_d     = done_q;
        pass_d     = pass_q;
        to_d       = to_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RUN;
                    tt_d       = truth_table;
                    err_d      = '0;
                    fe_valid_d = 1'b0;
                    fe_vec_d   = '0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    to_d       = 1'b0;
                end
            end
            RUN: begin
                if (accept_w) begin
                    err_d = err_inc_w;
                    if (mismatch_w && !fe_valid_q) begin
                        fe_valid_d = 1'b1;
                        fe_vec_d   = in_vec;
                    end
                    if (all_cov_next_w) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_inc_w == '0);
                    end
                end else if (timeout_fire_w) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                    pass_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tt_q       <= '0;
            err_q      <= '0;
            fe_valid_q <= 1'b0;
            fe_vec_q   <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tt_q       <= tt_d;
            err_q      <= err_d;
            fe_valid_q <= fe_valid_d;
            fe_vec_q   <= fe_vec_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            to_q       <= to_d;
        end
    end

    assign in_ready        = (state_q == RUN);
    assign busy            = (state_q == RUN);
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_valid = fe_valid_q;
    assign first_err_vec   = fe_vec_q;
    assign timeout         = to_q;

endmodule

`default_nettype wire
